// File: rtl/axil_mst_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axil_mst_pkg;

  localparam int AXIL_DATA_WIDTH = 32;
  localparam int STRB_WIDTH      = AXIL_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WB   = 3'd2,
    RA   = 3'd3,
    RD   = 3'd4,
    RSP  = 3'd5
  } state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: each valid/ready register command becomes one AXI-Lite write or read.
// Latency: rsp_valid 3 cycles after the cmd handshake against a 0-wait slave; one transaction in flight.
// Backpressure: cmd_ready low outside IDLE; response held until rsp_ready. AXIL_MST_STATS_EN adds counters.
module axil_cmd_master
  import axil_mst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
`ifdef AXIL_MST_STATS_EN
  ,
  parameter int STAT_WIDTH = 32
`endif
) (
  input  logic                  user_clk,
  input  logic                  user_reset,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
`ifdef AXIL_MST_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_wr_cnt,
  output logic [STAT_WIDTH-1:0] stat_rd_cnt,
  output logic [STAT_WIDTH-1:0] stat_err_cnt
`endif
);

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  we_q;
  logic                  aw_done, w_done;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;

  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_all, w_all;

  assign cmd_hs = cmd_valid & cmd_ready;
  assign aw_hs  = m_axil_awvalid & m_axil_awready;
  assign w_hs   = m_axil_wvalid & m_axil_wready;
  assign b_hs   = m_axil_bready & m_axil_bvalid;
  assign ar_hs  = m_axil_arvalid & m_axil_arready;
  assign r_hs   = m_axil_rready & m_axil_rvalid;
  assign aw_all = aw_done | aw_hs;
  assign w_all  = w_done | w_hs;

  always_ff @(posedge user_clk) begin
    if (user_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_hs) state_nxt = cmd_we ? WR : RA;
      WR:      if (aw_all && w_all) state_nxt = WB;
      WB:      if (b_hs) state_nxt = RSP;
      RA:      if (ar_hs) state_nxt = RD;
      RD:      if (r_hs) state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready is masked while reset is held so nothing is accepted during reset.
  always_comb begin
    cmd_ready      = (state == IDLE) && !user_reset;
    m_axil_awvalid = (state == WR) && !aw_done;
    m_axil_wvalid  = (state == WR) && !w_done;
    m_axil_bready  = (state == WB);
    m_axil_arvalid = (state == RA);
    m_axil_rready  = (state == RD);
    rsp_valid      = (state == RSP);
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      if (cmd_hs) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        we_q    <= cmd_we;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (b_hs) begin
        rdata_q <= '0;
        resp_q  <= m_axil_bresp;
      end else if (r_hs) begin
        rdata_q <= m_axil_rdata;
        resp_q  <= m_axil_rresp;
      end
    end
  end

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign rsp_we        = we_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

`ifdef AXIL_MST_STATS_EN
  logic err_evt;
  assign err_evt = (b_hs && resp_is_err(m_axil_bresp)) || (r_hs && resp_is_err(m_axil_rresp));

  // Counters saturate rather than wrap so long soak runs never read back as small values.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      stat_wr_cnt  <= '0;
      stat_rd_cnt  <= '0;
      stat_err_cnt <= '0;
    end else begin
      if (b_hs && stat_wr_cnt != '1)     stat_wr_cnt  <= stat_wr_cnt + 1'b1;
      if (r_hs && stat_rd_cnt != '1)     stat_rd_cnt  <= stat_rd_cnt + 1'b1;
      if (err_evt && stat_err_cnt != '1) stat_err_cnt <= stat_err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master against a small register-file AXI-Lite slave model.
module tb_axil_cmd_master;
  import axil_mst_pkg::*;

  logic        user_clk = 1'b0;
  logic        user_reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
`ifdef AXIL_MST_STATS_EN
  logic [31:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) cyc <= cyc + 1;

  axil_cmd_master dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
    .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready), .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid),
    .m_axil_arready(m_axil_arready), .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
`ifdef AXIL_MST_STATS_EN
    , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_err_cnt(stat_err_cnt)
`endif
  );

  // Slave model: configurable ready stalls, 16-word register file, one-cycle response.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic [1:0]  bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
  logic        b_hold = 1'b0;
  int          aw_wait, w_wait, ar_wait;
  logic        aw_got, w_got, b_pend;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] mem [16];
  int          aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0, ar_stall_cnt = 0, viol_cnt = 0;
  logic        prev_awv, prev_awr, prev_wv, prev_wr, prev_arv, prev_arr;

  assign m_axil_awready = m_axil_awvalid && (aw_wait >= aw_dly);
  assign m_axil_wready  = m_axil_wvalid && (w_wait >= w_dly);
  assign m_axil_arready = m_axil_arvalid && (ar_wait >= ar_dly);

  always @(posedge user_clk) begin : slave
    logic [31:0] c_addr, c_data;
    logic [3:0]  c_strb;
    if (user_reset) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
      m_axil_bvalid <= 1'b0; m_axil_rvalid <= 1'b0;
      m_axil_bresp <= 2'b00; m_axil_rresp <= 2'b00; m_axil_rdata <= '0;
      prev_awv <= 1'b0; prev_wv <= 1'b0; prev_arv <= 1'b0;
      prev_awr <= 1'b0; prev_wr <= 1'b0; prev_arr <= 1'b0;
    end else begin
      if (prev_awv && !prev_awr && !m_axil_awvalid) viol_cnt <= viol_cnt + 1;
      if (prev_wv && !prev_wr && !m_axil_wvalid)    viol_cnt <= viol_cnt + 1;
      if (prev_arv && !prev_arr && !m_axil_arvalid) viol_cnt <= viol_cnt + 1;
      prev_awv <= m_axil_awvalid; prev_awr <= m_axil_awready;
      prev_wv  <= m_axil_wvalid;  prev_wr  <= m_axil_wready;
      prev_arv <= m_axil_arvalid; prev_arr <= m_axil_arready;
      aw_wait <= (m_axil_awvalid && !m_axil_awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_axil_wvalid && !m_axil_wready) ? w_wait + 1 : 0;
      ar_wait <= (m_axil_arvalid && !m_axil_arready) ? ar_wait + 1 : 0;
      if (m_axil_arvalid && !m_axil_arready) ar_stall_cnt <= ar_stall_cnt + 1;

      c_addr = aw_got ? s_awaddr : m_axil_awaddr;
      c_data = w_got ? s_wdata : m_axil_wdata;
      c_strb = w_got ? s_wstrb : m_axil_wstrb;
      if (m_axil_awvalid && m_axil_awready) begin
        aw_hs_cnt <= aw_hs_cnt + 1; aw_got <= 1'b1; s_awaddr <= m_axil_awaddr;
      end
      if (m_axil_wvalid && m_axil_wready) begin
        w_hs_cnt <= w_hs_cnt + 1; w_got <= 1'b1;
        s_wdata <= m_axil_wdata; s_wstrb <= m_axil_wstrb;
      end
      if ((aw_got || (m_axil_awvalid && m_axil_awready)) &&
          (w_got || (m_axil_wvalid && m_axil_wready)) && !m_axil_bvalid && !b_pend) begin
        for (int b = 0; b < 4; b++)
          if (c_strb[b]) mem[c_addr[5:2]][8*b +: 8] <= c_data[8*b +: 8];
        aw_got <= 1'b0; w_got <= 1'b0;
        m_axil_bresp <= bresp_cfg;
        m_axil_bvalid <= !b_hold;
        b_pend <= b_hold;
      end else if (b_pend && !b_hold) begin
        m_axil_bvalid <= 1'b1; b_pend <= 1'b0;
      end
      if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 1'b0;

      if (m_axil_arvalid && m_axil_arready) begin
        ar_hs_cnt <= ar_hs_cnt + 1;
        m_axil_rvalid <= 1'b1;
        m_axil_rdata <= mem[m_axil_araddr[5:2]];
        m_axil_rresp <= rresp_cfg;
      end else if (m_axil_rvalid && m_axil_rready) begin
        m_axil_rvalid <= 1'b0;
      end
    end
  end

  // Issues one command from a negedge and returns the response; lat counts cycles handshake->rsp_valid.
  task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int hold,
                        output logic r_we, output logic [31:0] r_data, output logic [1:0] r_resp,
                        output int lat, output logic stable);
    int c0, n;
    stable = 1'b1; lat = -1; r_we = 1'bx; r_data = 'x; r_resp = 'x;
    cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge user_clk); n++; end
    if (n >= 50) begin
      checks++; fails++; cmd_valid = 1'b0;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      return;
    end
    c0 = cyc;
    @(negedge user_clk);
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin @(negedge user_clk); n++; end
    if (n >= 100) begin
      checks++; fails++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
      return;
    end
    lat = cyc - c0;
    r_we = rsp_we; r_data = rsp_rdata; r_resp = rsp_resp;
    if (cmd_ready !== 1'b0) stable = 1'b0;
    repeat (hold) begin
      @(negedge user_clk);
      if (rsp_valid !== 1'b1 || rsp_we !== r_we || rsp_rdata !== r_data ||
          rsp_resp !== r_resp || cmd_ready !== 1'b0) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge user_clk);
    rsp_ready = 1'b0;
  endtask

  logic        t_we, t_st;
  logic [31:0] t_data;
  logic [1:0]  t_resp;
  int          t_lat;

  task automatic test_reset();
    user_reset = 1'b1;
    repeat (3) @(negedge user_clk);
    checks++;
    if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready, rsp_valid} !== 6'b0) begin
      fails++;
      $display("FAIL reset_valids: got %b, required 000000",
               {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready, rsp_valid});
    end
    checks++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready); end
    checks++;
    if ({rsp_we, rsp_rdata, rsp_resp} !== 35'd0) begin
      fails++; $display("FAIL reset_rsp_regs: we=%b rdata=%h resp=%b, required 0", rsp_we, rsp_rdata, rsp_resp);
    end
    user_reset = 1'b0;
    @(negedge user_clk);
    checks++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL post_reset_cmd_ready: got %b, required 1", cmd_ready); end
  endtask

  task automatic test_write_basic();
    int aw0, w0;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    do_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, t_we, t_data, t_resp, t_lat, t_st);
    checks++;
    if (t_lat !== 3) begin fails++; $display("FAIL wr_latency: got %0d, required 3", t_lat); end
    checks++;
    if ({t_we, t_data, t_resp} !== {1'b1, 32'h0, 2'b00}) begin
      fails++; $display("FAIL wr_rsp: we=%b rdata=%h resp=%b, required 1/00000000/00", t_we, t_data, t_resp);
    end
    checks++;
    if (aw_hs_cnt - aw0 !== 1 || w_hs_cnt - w0 !== 1) begin
      fails++; $display("FAIL wr_beats: aw=%0d w=%0d, required 1/1", aw_hs_cnt - aw0, w_hs_cnt - w0);
    end
    checks++;
    if (s_awaddr !== 32'h10 || s_wdata !== 32'hDEAD_BEEF || s_wstrb !== 4'hF) begin
      fails++; $display("FAIL wr_beat_values: addr=%h data=%h strb=%h, required 00000010/deadbeef/f",
                        s_awaddr, s_wdata, s_wstrb);
    end
  endtask

  task automatic test_read_stall();
    int st0;
    do_cmd(1'b1, 32'h0000_0014, 32'h1234_5678, 4'hF, 0, t_we, t_data, t_resp, t_lat, t_st);
    ar_dly = 5; st0 = ar_stall_cnt;
    do_cmd(1'b0, 32'h0000_0014, 32'h0, 4'h0, 0, t_we, t_data, t_resp, t_lat, t_st);
    ar_dly = 0;
    checks++;
    if (ar_stall_cnt - st0 !== 5) begin fails++; $display("FAIL rd_ar_stall: got %0d, required 5", ar_stall_cnt - st0); end
    checks++;
    if ({t_we, t_data, t_resp} !== {1'b0, 32'h1234_5678, 2'b00}) begin
      fails++; $display("FAIL rd_rsp: we=%b rdata=%h resp=%b, required 0/12345678/00", t_we, t_data, t_resp);
    end
    checks++;
    if (t_lat !== 8) begin fails++; $display("FAIL rd_stall_latency: got %0d, required 8", t_lat); end
  endtask

  task automatic test_write_order();
    int awd [3] = '{0, 3, 2};
    int wd  [3] = '{3, 0, 2};
    int lx  [3] = '{6, 6, 5};
    logic [31:0] dv [3] = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};
    int aw0, w0;
    for (int i = 0; i < 3; i++) begin
      aw_dly = awd[i]; w_dly = wd[i];
      aw0 = aw_hs_cnt; w0 = w_hs_cnt;
      do_cmd(1'b1, 32'h20 + 32'(4*i), dv[i], 4'hF, 0, t_we, t_data, t_resp, t_lat, t_st);
      aw_dly = 0; w_dly = 0;
      checks++;
      if (aw_hs_cnt - aw0 !== 1 || w_hs_cnt - w0 !== 1) begin
        fails++; $display("FAIL order%0d_beats: aw=%0d w=%0d, required 1/1", i, aw_hs_cnt - aw0, w_hs_cnt - w0);
      end
      checks++;
      if (t_lat !== lx[i]) begin fails++; $display("FAIL order%0d_latency: got %0d, required %0d", i, t_lat, lx[i]); end
      do_cmd(1'b0, 32'h20 + 32'(4*i), 32'h0, 4'h0, 0, t_we, t_data, t_resp, t_lat, t_st);
      checks++;
      if (t_data !== dv[i]) begin fails++; $display("FAIL order%0d_readback: got %h, required %h", i, t_data, dv[i]); end
    end
    checks++;
    if (viol_cnt !== 0) begin fails++; $display("FAIL valid_drop_before_ready: got %0d, required 0", viol_cnt); end
  endtask

  task automatic test_err_hold();
`ifdef AXIL_MST_STATS_EN
    logic [31:0] e0, r0;
    e0 = stat_err_cnt; r0 = stat_rd_cnt;
`endif
    rresp_cfg = RESP_SLVERR;
    do_cmd(1'b0, 32'h0000_0014, 32'h0, 4'h0, 4, t_we, t_data, t_resp, t_lat, t_st);
    rresp_cfg = RESP_OKAY;
    checks++;
    if (t_resp !== RESP_SLVERR || t_data !== 32'h1234_5678) begin
      fails++; $display("FAIL err_rsp: resp=%b rdata=%h, required 10/12345678", t_resp, t_data);
    end
    checks++;
    if (t_st !== 1'b1) begin fails++; $display("FAIL err_hold_stable: got %b, required 1", t_st); end
`ifdef AXIL_MST_STATS_EN
    checks++;
    if (stat_err_cnt - e0 !== 1 || stat_rd_cnt - r0 !== 1) begin
      fails++; $display("FAIL err_stats: err+%0d rd+%0d, required 1/1", stat_err_cnt - e0, stat_rd_cnt - r0);
    end
`endif
  endtask

  task automatic test_reset_in_wb();
    int n;
    b_hold = 1'b1;
    cmd_we = 1'b1; cmd_addr = 32'h3C; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    @(negedge user_clk);
    cmd_valid = 1'b0;
    n = 0;
    while (m_axil_bready !== 1'b1 && n < 20) begin @(negedge user_clk); n++; end
    checks++;
    if (m_axil_bready !== 1'b1 || m_axil_bvalid !== 1'b0) begin
      fails++; $display("FAIL wb_reached: bready=%b bvalid=%b, required 1/0", m_axil_bready, m_axil_bvalid);
    end
    user_reset = 1'b1;
    @(negedge user_clk);
    checks++;
    if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready, rsp_valid} !== 6'b0) begin
      fails++;
      $display("FAIL wb_reset_valids: got %b, required 000000",
               {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready, rsp_valid});
    end
    user_reset = 1'b0; b_hold = 1'b0;
    @(negedge user_clk);
    checks++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL wb_reset_idle: cmd_ready=%b, required 1", cmd_ready); end
    do_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, t_we, t_data, t_resp, t_lat, t_st);
    checks++;
    if (t_data !== 32'hDEAD_BEEF || t_lat !== 3) begin
      fails++; $display("FAIL wb_reset_recover: rdata=%h lat=%0d, required deadbeef/3", t_data, t_lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ref_mem [16];
    logic        we;
    logic [3:0]  idx, strb;
    logic [31:0] d, exp;
    int          beats0, bad;
`ifdef AXIL_MST_STATS_EN
    logic [31:0] sw0, sr0;
`endif
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h5A00_0000 | 32'(i * 17);
      do_cmd(1'b1, 32'(4*i), ref_mem[i], 4'hF, 0, t_we, t_data, t_resp, t_lat, t_st);
    end
    beats0 = aw_hs_cnt + ar_hs_cnt; bad = 0;
`ifdef AXIL_MST_STATS_EN
    sw0 = stat_wr_cnt; sr0 = stat_rd_cnt;
`endif
    for (int k = 0; k < 100; k++) begin
      we = 1'($urandom_range(0, 1)); idx = 4'($urandom_range(0, 15));
      d = $urandom; strb = 4'($urandom_range(1, 15));
      aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2); ar_dly = $urandom_range(0, 2);
      do_cmd(we, {26'd0, idx, 2'b00}, d, strb, 0, t_we, t_data, t_resp, t_lat, t_st);
      if (we) begin
        for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        exp = 32'h0;
      end else begin
        exp = ref_mem[idx];
      end
      checks++;
      if (t_we !== we || t_data !== exp || t_resp !== RESP_OKAY) begin
        fails++; bad++;
        if (bad <= 5)
          $display("FAIL b2b_cmd%0d: we=%b rdata=%h resp=%b, required we=%b rdata=%h resp=00",
                   k, t_we, t_data, t_resp, we, exp);
      end
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0;
    checks++;
    if (aw_hs_cnt + ar_hs_cnt - beats0 !== 100) begin
      fails++; $display("FAIL b2b_beat_total: got %0d, required 100", aw_hs_cnt + ar_hs_cnt - beats0);
    end
`ifdef AXIL_MST_STATS_EN
    checks++;
    if ((stat_wr_cnt - sw0) + (stat_rd_cnt - sr0) !== 100) begin
      fails++; $display("FAIL b2b_stats_sum: got %0d, required 100", (stat_wr_cnt - sw0) + (stat_rd_cnt - sr0));
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_read_stall();
    test_write_order();
    test_err_hold();
    test_reset_in_wb();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
